// File: rtl/mips_pipe_control.sv
// Pipelined MIPS control unit: D-stage decode, E/M/W control pipeline registers,
// and a multi-cycle multiply sequencer that holds the pipeline while busy.

module mips_pipe_control_chk (
   input logic clk,
   input logic rst_n,
   input logic stall,
   input logic done,
   input logic reg_write_e
);

   // A completion pulse only ever occurs inside a busy window
   done_in_busy_a : assert property (@(posedge clk) disable iff (!rst_n) done |-> stall);

   // While stalled the E stage never carries a register write
   bubble_in_busy_a : assert property (@(posedge clk) disable iff (!rst_n) stall |-> !reg_write_e);

endmodule

module mips_pipe_control #(
   parameter int ALU_CTRL_W    = 3,
   parameter int MULDIV_LAT    = 4,
   parameter int ENABLE_MULDIV = 1
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic [5:0]            i_Op,
   input  logic [5:0]            i_funct,
   input  logic                  i_FlushE,
   output logic                  o_RegWriteD,
   output logic                  o_MemtoRegD,
   output logic                  o_MemWriteD,
   output logic                  o_ALUSrcD,
   output logic                  o_RegDstD,
   output logic                  o_BranchD,
   output logic                  o_JumpD,
   output logic [ALU_CTRL_W-1:0] o_ALUControlD,
   output logic                  o_IllegalD,
   output logic                  o_RegWriteE,
   output logic                  o_MemtoRegE,
   output logic                  o_MemWriteE,
   output logic                  o_ALUSrcE,
   output logic                  o_RegDstE,
   output logic                  o_MulStartE,
   output logic [ALU_CTRL_W-1:0] o_ALUControlE,
   output logic                  o_RegWriteM,
   output logic                  o_MemtoRegM,
   output logic                  o_MemWriteM,
   output logic                  o_RegWriteW,
   output logic                  o_MemtoRegW,
   output logic                  o_StallReq,
   output logic                  o_MulDone
);

   localparam int CNT_W = $clog2(MULDIV_LAT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 32'sd2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'sd0);
   localparam logic MULDIV_EN = (ENABLE_MULDIV != 32'sd0);

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_MULT = 6'b011000;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mul_state_t;

   // Zero-extend a 3-bit ALU code to the configured control width
   function automatic logic [ALU_CTRL_W-1:0] alu_code(input logic [2:0] code);
      logic [ALU_CTRL_W-1:0] r;
      r      = '0;
      r[2:0] = code;
      return r;
   endfunction

   mul_state_t            state_r;
   logic [CNT_W-1:0]      cnt_r;
   logic                  stall_r;
   logic                  done_r;

   logic                  reg_write_s;
   logic                  mem_to_reg_s;
   logic                  mem_write_s;
   logic                  alu_src_s;
   logic                  reg_dst_s;
   logic                  branch_s;
   logic                  jump_s;
   logic [ALU_CTRL_W-1:0] alu_ctrl_s;
   logic                  illegal_s;
   logic                  mult_s;

   logic                  reg_write_e_r;
   logic                  mem_to_reg_e_r;
   logic                  mem_write_e_r;
   logic                  alu_src_e_r;
   logic                  reg_dst_e_r;
   logic                  mul_start_e_r;
   logic [ALU_CTRL_W-1:0] alu_ctrl_e_r;
   logic                  reg_write_m_r;
   logic                  mem_to_reg_m_r;
   logic                  mem_write_m_r;
   logic                  reg_write_w_r;
   logic                  mem_to_reg_w_r;

   // D-stage opcode/funct decode
   always_comb begin
      reg_write_s  = 1'b0;
      mem_to_reg_s = 1'b0;
      mem_write_s  = 1'b0;
      alu_src_s    = 1'b0;
      reg_dst_s    = 1'b0;
      branch_s     = 1'b0;
      jump_s       = 1'b0;
      alu_ctrl_s   = alu_code(ALU_AND);
      illegal_s    = 1'b0;
      mult_s       = 1'b0;
      case (i_Op)
         OP_RTYPE: begin
            case (i_funct)
               FN_ADD: begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = alu_code(ALU_ADD); end
               FN_SUB: begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = alu_code(ALU_SUB); end
               FN_AND: begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = alu_code(ALU_AND); end
               FN_OR:  begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = alu_code(ALU_OR);  end
               FN_SLT: begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = alu_code(ALU_SLT); end
               FN_MULT: begin
                  if (MULDIV_EN) begin
                     mult_s = 1'b1;
                  end else begin
                     illegal_s = 1'b1;
                  end
               end
               default: illegal_s = 1'b1;
            endcase
         end
         OP_LW: begin
            reg_write_s  = 1'b1;
            alu_src_s    = 1'b1;
            mem_to_reg_s = 1'b1;
            alu_ctrl_s   = alu_code(ALU_ADD);
         end
         OP_SW: begin
            mem_write_s = 1'b1;
            alu_src_s   = 1'b1;
            alu_ctrl_s  = alu_code(ALU_ADD);
         end
         OP_BEQ: begin
            branch_s   = 1'b1;
            alu_ctrl_s = alu_code(ALU_SUB);
         end
         OP_ADDI: begin
            reg_write_s = 1'b1;
            alu_src_s   = 1'b1;
            alu_ctrl_s  = alu_code(ALU_ADD);
         end
         OP_J:    jump_s = 1'b1;
         default: illegal_s = 1'b1;
      endcase
   end

   // Multiply sequencer; stall/done are registered from the next state and count
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         stall_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (mult_s && !i_FlushE) begin
                  state_r <= BUSY;
                  cnt_r   <= CNT_LOAD;
                  stall_r <= 1'b1;
                  done_r  <= (CNT_LOAD == CNT_ZERO);
               end else begin
                  stall_r <= 1'b0;
                  done_r  <= 1'b0;
               end
            end
            BUSY: begin
               if (cnt_r == CNT_ZERO) begin
                  state_r <= IDLE;
                  stall_r <= 1'b0;
                  done_r  <= 1'b0;
               end else begin
                  cnt_r   <= cnt_r - CNT_ONE;
                  stall_r <= 1'b1;
                  done_r  <= (cnt_r == CNT_ONE);
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= CNT_ZERO;
               stall_r <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // E register: bubble on flush or while the multiplier owns the pipeline
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         reg_write_e_r  <= 1'b0;
         mem_to_reg_e_r <= 1'b0;
         mem_write_e_r  <= 1'b0;
         alu_src_e_r    <= 1'b0;
         reg_dst_e_r    <= 1'b0;
         mul_start_e_r  <= 1'b0;
         alu_ctrl_e_r   <= '0;
      end else if (i_FlushE || (state_r == BUSY)) begin
         reg_write_e_r  <= 1'b0;
         mem_to_reg_e_r <= 1'b0;
         mem_write_e_r  <= 1'b0;
         alu_src_e_r    <= 1'b0;
         reg_dst_e_r    <= 1'b0;
         mul_start_e_r  <= 1'b0;
         alu_ctrl_e_r   <= '0;
      end else begin
         reg_write_e_r  <= reg_write_s;
         mem_to_reg_e_r <= mem_to_reg_s;
         mem_write_e_r  <= mem_write_s;
         alu_src_e_r    <= alu_src_s;
         reg_dst_e_r    <= reg_dst_s;
         mul_start_e_r  <= mult_s;
         alu_ctrl_e_r   <= alu_ctrl_s;
      end
   end

   // M and W registers advance unconditionally
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         reg_write_m_r  <= 1'b0;
         mem_to_reg_m_r <= 1'b0;
         mem_write_m_r  <= 1'b0;
         reg_write_w_r  <= 1'b0;
         mem_to_reg_w_r <= 1'b0;
      end else begin
         reg_write_m_r  <= reg_write_e_r;
         mem_to_reg_m_r <= mem_to_reg_e_r;
         mem_write_m_r  <= mem_write_e_r;
         reg_write_w_r  <= reg_write_m_r;
         mem_to_reg_w_r <= mem_to_reg_m_r;
      end
   end

   assign o_RegWriteD   = reg_write_s;
   assign o_MemtoRegD   = mem_to_reg_s;
   assign o_MemWriteD   = mem_write_s;
   assign o_ALUSrcD     = alu_src_s;
   assign o_RegDstD     = reg_dst_s;
   assign o_BranchD     = branch_s;
   assign o_JumpD       = jump_s;
   assign o_ALUControlD = alu_ctrl_s;
   assign o_IllegalD    = illegal_s;

   assign o_RegWriteE   = reg_write_e_r;
   assign o_MemtoRegE   = mem_to_reg_e_r;
   assign o_MemWriteE   = mem_write_e_r;
   assign o_ALUSrcE     = alu_src_e_r;
   assign o_RegDstE     = reg_dst_e_r;
   assign o_MulStartE   = mul_start_e_r;
   assign o_ALUControlE = alu_ctrl_e_r;

   assign o_RegWriteM   = reg_write_m_r;
   assign o_MemtoRegM   = mem_to_reg_m_r;
   assign o_MemWriteM   = mem_write_m_r;
   assign o_RegWriteW   = reg_write_w_r;
   assign o_MemtoRegW   = mem_to_reg_w_r;

   assign o_StallReq    = stall_r;
   assign o_MulDone     = done_r;

   mips_pipe_control_chk u_chk (
      .clk         (i_CLK),
      .rst_n       (i_RST),
      .stall       (stall_r),
      .done        (done_r),
      .reg_write_e (reg_write_e_r)
   );

endmodule

// File: tb/tb_mips_pipe_control.sv
// Bench for mips_pipe_control: table-driven decode/pipeline checks with a queue
// scoreboard, plus hand-written multiply, flush and reset sequences.

module tb_mips_pipe_control;

   logic       clk;
   logic       rst;
   logic [5:0] op;
   logic [5:0] funct;
   logic       flush;

   // Main DUT (MULDIV_LAT=4, multiply enabled)
   logic       rw_d, m2r_d, mw_d, src_d, dst_d, br_d, j_d, ill_d;
   logic [2:0] alu_d;
   logic       rw_e, m2r_e, mw_e, src_e, dst_e, ms_e;
   logic [2:0] alu_e;
   logic       rw_m, m2r_m, mw_m, rw_w, m2r_w, stall, done;

   // Multiply disabled variant
   logic       nrw_d, nm2r_d, nmw_d, nsrc_d, ndst_d, nbr_d, nj_d, nill_d;
   logic [2:0] nalu_d, nalu_e;
   logic       nrw_e, nm2r_e, nmw_e, nsrc_e, ndst_e, nms_e;
   logic       nrw_m, nm2r_m, nmw_m, nrw_w, nm2r_w, nstall, ndone;

   // MULDIV_LAT=2 variant
   logic       trw_d, tm2r_d, tmw_d, tsrc_d, tdst_d, tbr_d, tj_d, till_d;
   logic [2:0] talu_d, talu_e;
   logic       trw_e, tm2r_e, tmw_e, tsrc_e, tdst_e, tms_e;
   logic       trw_m, tm2r_m, tmw_m, trw_w, tm2r_w, tstall, tdone;

   mips_pipe_control #(.ALU_CTRL_W(3), .MULDIV_LAT(4), .ENABLE_MULDIV(1)) dut (
      .i_CLK(clk), .i_RST(rst), .i_Op(op), .i_funct(funct), .i_FlushE(flush),
      .o_RegWriteD(rw_d), .o_MemtoRegD(m2r_d), .o_MemWriteD(mw_d), .o_ALUSrcD(src_d),
      .o_RegDstD(dst_d), .o_BranchD(br_d), .o_JumpD(j_d), .o_ALUControlD(alu_d),
      .o_IllegalD(ill_d), .o_RegWriteE(rw_e), .o_MemtoRegE(m2r_e), .o_MemWriteE(mw_e),
      .o_ALUSrcE(src_e), .o_RegDstE(dst_e), .o_MulStartE(ms_e), .o_ALUControlE(alu_e),
      .o_RegWriteM(rw_m), .o_MemtoRegM(m2r_m), .o_MemWriteM(mw_m), .o_RegWriteW(rw_w),
      .o_MemtoRegW(m2r_w), .o_StallReq(stall), .o_MulDone(done));

   mips_pipe_control #(.ALU_CTRL_W(3), .MULDIV_LAT(4), .ENABLE_MULDIV(0)) dut_nm (
      .i_CLK(clk), .i_RST(rst), .i_Op(op), .i_funct(funct), .i_FlushE(flush),
      .o_RegWriteD(nrw_d), .o_MemtoRegD(nm2r_d), .o_MemWriteD(nmw_d), .o_ALUSrcD(nsrc_d),
      .o_RegDstD(ndst_d), .o_BranchD(nbr_d), .o_JumpD(nj_d), .o_ALUControlD(nalu_d),
      .o_IllegalD(nill_d), .o_RegWriteE(nrw_e), .o_MemtoRegE(nm2r_e), .o_MemWriteE(nmw_e),
      .o_ALUSrcE(nsrc_e), .o_RegDstE(ndst_e), .o_MulStartE(nms_e), .o_ALUControlE(nalu_e),
      .o_RegWriteM(nrw_m), .o_MemtoRegM(nm2r_m), .o_MemWriteM(nmw_m), .o_RegWriteW(nrw_w),
      .o_MemtoRegW(nm2r_w), .o_StallReq(nstall), .o_MulDone(ndone));

   mips_pipe_control #(.ALU_CTRL_W(3), .MULDIV_LAT(2), .ENABLE_MULDIV(1)) dut2 (
      .i_CLK(clk), .i_RST(rst), .i_Op(op), .i_funct(funct), .i_FlushE(flush),
      .o_RegWriteD(trw_d), .o_MemtoRegD(tm2r_d), .o_MemWriteD(tmw_d), .o_ALUSrcD(tsrc_d),
      .o_RegDstD(tdst_d), .o_BranchD(tbr_d), .o_JumpD(tj_d), .o_ALUControlD(talu_d),
      .o_IllegalD(till_d), .o_RegWriteE(trw_e), .o_MemtoRegE(tm2r_e), .o_MemWriteE(tmw_e),
      .o_ALUSrcE(tsrc_e), .o_RegDstE(tdst_e), .o_MulStartE(tms_e), .o_ALUControlE(talu_e),
      .o_RegWriteM(trw_m), .o_MemtoRegM(tm2r_m), .o_MemWriteM(tmw_m), .o_RegWriteW(trw_w),
      .o_MemtoRegW(tm2r_w), .o_StallReq(tstall), .o_MulDone(tdone));

   // D vector: {rw, m2r, mw, alusrc, regdst, branch, jump, alu[2:0], illegal}
   // E vector: {rw, m2r, mw, alusrc, regdst, mulstart, alu[2:0]}
   logic [10:0] d_act;
   logic [8:0]  e_act;
   logic [2:0]  m_act;
   logic [1:0]  w_act;
   assign d_act = {rw_d, m2r_d, mw_d, src_d, dst_d, br_d, j_d, alu_d, ill_d};
   assign e_act = {rw_e, m2r_e, mw_e, src_e, dst_e, ms_e, alu_e};
   assign m_act = {rw_m, m2r_m, mw_m};
   assign w_act = {rw_w, m2r_w};

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        flush;
      logic [10:0] exp_d;
   } vec_t;

   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [8:0] E_ADD   = 9'b10001_0_010;
   localparam logic [8:0] E_MUL   = 9'b00000_1_000;

   vec_t       vecs[$];
   logic [8:0] qe[$];
   logic [8:0] model_e, model_m, model_w, exp_e;
   int         checks;
   int         failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic fl);
      op    = o;
      funct = f;
      flush = fl;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      drive(6'b100011, 6'b000000, 1'b0);

      vecs.push_back('{6'b100011, 6'b000000, 1'b0, 11'b1_1_0_1_0_0_0_010_0}); // lw
      vecs.push_back('{6'b101011, 6'b000000, 1'b0, 11'b0_0_1_1_0_0_0_010_0}); // sw
      vecs.push_back('{6'b000100, 6'b000000, 1'b0, 11'b0_0_0_0_0_1_0_110_0}); // beq
      vecs.push_back('{6'b001000, 6'b000000, 1'b0, 11'b1_0_0_1_0_0_0_010_0}); // addi
      vecs.push_back('{6'b000010, 6'b000000, 1'b0, 11'b0_0_0_0_0_0_1_000_0}); // j
      vecs.push_back('{6'b000000, 6'b100000, 1'b0, 11'b1_0_0_0_1_0_0_010_0}); // add
      vecs.push_back('{6'b000000, 6'b100010, 1'b0, 11'b1_0_0_0_1_0_0_110_0}); // sub
      vecs.push_back('{6'b000000, 6'b100100, 1'b0, 11'b1_0_0_0_1_0_0_000_0}); // and
      vecs.push_back('{6'b000000, 6'b100101, 1'b0, 11'b1_0_0_0_1_0_0_001_0}); // or
      vecs.push_back('{6'b000000, 6'b101010, 1'b0, 11'b1_0_0_0_1_0_0_111_0}); // slt
      vecs.push_back('{6'b000000, 6'b000001, 1'b0, 11'b0_0_0_0_0_0_0_000_1}); // bad funct
      vecs.push_back('{6'b111111, 6'b100000, 1'b0, 11'b0_0_0_0_0_0_0_000_1}); // bad op
      vecs.push_back('{6'b101011, 6'b000000, 1'b1, 11'b0_0_1_1_0_0_0_010_0}); // sw flushed
      vecs.push_back('{6'b100011, 6'b000000, 1'b0, 11'b1_1_0_1_0_0_0_010_0}); // lw
      vecs.push_back('{6'b001000, 6'b000000, 1'b1, 11'b1_0_0_1_0_0_0_010_0}); // addi flushed
      vecs.push_back('{6'b000000, 6'b100010, 1'b0, 11'b1_0_0_0_1_0_0_110_0}); // sub
      vecs.push_back('{6'b001000, 6'b000000, 1'b0, 11'b1_0_0_1_0_0_0_010_0}); // drain
      vecs.push_back('{6'b001000, 6'b000000, 1'b0, 11'b1_0_0_1_0_0_0_010_0}); // drain
      vecs.push_back('{6'b001000, 6'b000000, 1'b0, 11'b1_0_0_1_0_0_0_010_0}); // drain

      // Reset held across edges with lw in D
      tick();
      tick();
      chk("reset_e", {23'd0, e_act}, 32'd0);
      chk("reset_m", {29'd0, m_act}, 32'd0);
      chk("reset_w", {30'd0, w_act}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      rst     = 1'b1;
      model_e = 9'd0;
      model_m = 9'd0;
      model_w = 9'd0;

      // Table phase: expected E pushed at drive time, popped after the edge
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].funct, vecs[i].flush);
         #1;
         chk($sformatf("dec_d[%0d]", i), {21'd0, d_act}, {21'd0, vecs[i].exp_d});
         exp_e = vecs[i].flush ? 9'd0 : {vecs[i].exp_d[10:6], 1'b0, vecs[i].exp_d[3:1]};
         qe.push_back(exp_e);
         tick();
         model_w = model_m;
         model_m = model_e;
         model_e = qe.pop_front();
         chk($sformatf("pipe_e[%0d]", i), {23'd0, e_act}, {23'd0, model_e});
         chk($sformatf("pipe_m[%0d]", i), {29'd0, m_act}, {29'd0, model_m[8:6]});
         chk($sformatf("pipe_w[%0d]", i), {30'd0, w_act}, {30'd0, model_w[8:7]});
      end

      // MULT, LAT=4 on dut and LAT=2 on dut2
      drive(6'b000000, FN_MULT, 1'b0);
      #1;
      chk("mult_dec_d", {21'd0, d_act}, 32'd0);
      chk("nomul_illegal", {31'd0, nill_d}, 32'd1);
      tick();
      chk("mul_c1_e", {23'd0, e_act}, {23'd0, E_MUL});
      chk("mul_c1_stall", {31'd0, stall}, 32'd1);
      chk("mul_c1_done", {31'd0, done}, 32'd0);
      chk("lat2_c1_start", {31'd0, tms_e}, 32'd1);
      chk("lat2_c1_stall", {31'd0, tstall}, 32'd1);
      chk("lat2_c1_done", {31'd0, tdone}, 32'd1);
      drive(6'b000000, 6'b100000, 1'b0);
      tick();
      chk("mul_c2_e", {23'd0, e_act}, 32'd0);
      chk("mul_c2_stall", {31'd0, stall}, 32'd1);
      chk("mul_c2_done", {31'd0, done}, 32'd0);
      chk("lat2_c2_stall", {31'd0, tstall}, 32'd0);
      chk("lat2_c2_done", {31'd0, tdone}, 32'd0);
      tick();
      chk("mul_c3_e", {23'd0, e_act}, 32'd0);
      chk("mul_c3_stall", {31'd0, stall}, 32'd1);
      chk("mul_c3_done", {31'd0, done}, 32'd1);
      tick();
      chk("mul_c4_e", {23'd0, e_act}, 32'd0);
      chk("mul_c4_stall", {31'd0, stall}, 32'd0);
      chk("mul_c4_done", {31'd0, done}, 32'd0);
      tick();
      chk("mul_c5_e", {23'd0, e_act}, {23'd0, E_ADD});

      // Back-to-back MULT held in D
      drive(6'b000000, FN_MULT, 1'b0);
      tick();
      chk("b2b_start1", {31'd0, ms_e}, 32'd1);
      tick();
      tick();
      chk("b2b_busy_stall", {31'd0, stall}, 32'd1);
      tick();
      chk("b2b_idle_stall", {31'd0, stall}, 32'd0);
      chk("b2b_idle_start", {31'd0, ms_e}, 32'd0);
      tick();
      chk("b2b_start2", {31'd0, ms_e}, 32'd1);
      chk("b2b_stall2", {31'd0, stall}, 32'd1);
      drive(6'b000000, 6'b100000, 1'b0);
      tick();
      tick();
      chk("b2b_done2", {31'd0, done}, 32'd1);
      tick();
      chk("b2b_release", {31'd0, stall}, 32'd0);

      // MULT flushed while idle never enters BUSY
      drive(6'b000000, FN_MULT, 1'b1);
      tick();
      chk("flush_mul_stall", {31'd0, stall}, 32'd0);
      chk("flush_mul_e", {23'd0, e_act}, 32'd0);
      tick();
      chk("flush_mul_stall2", {31'd0, stall}, 32'd0);
      drive(6'b000000, 6'b100000, 1'b0);
      tick();

      // Reset in the second BUSY cycle aborts the multiply
      drive(6'b000000, FN_MULT, 1'b0);
      tick();
      chk("abort_c1_stall", {31'd0, stall}, 32'd1);
      drive(6'b000000, 6'b100000, 1'b0);
      tick();
      chk("abort_c2_stall", {31'd0, stall}, 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_stall", {31'd0, stall}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_e", {23'd0, e_act}, 32'd0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("abort_nodone[%0d]", k), {31'd0, done}, 32'd0);
         chk($sformatf("abort_nostall[%0d]", k), {31'd0, stall}, 32'd0);
      end
      chk("abort_resume_e", {23'd0, e_act}, {23'd0, E_ADD});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_pipe_control.md
# mips_pipe_control

Parametrised pipelined control unit for the MIPS core. Decodes opcode/funct in the Decode stage and carries the control bundle through Execute, Memory and Writeback pipeline registers. Supports bubble insertion from the hazard unit and a multi-cycle multiply sequencer that requests pipeline stalls for a configurable latency. Sits between the instruction register (D stage) and the datapath and hazard unit.

## Interface
- ALU_CTRL_W, 3: width of the ALU control code (codes zero-extended from 3 bits).
- MULDIV_LAT, 4: multiply latency in cycles, legal range ≥2.
- ENABLE_MULDIV, 1: 1 decodes MULT; 0 treats MULT as illegal.
- i_CLK  in  1  clock, rising edge.
- i_RST  in  1  asynchronous, active-low reset.
- i_Op  in  6  D-stage opcode.
- i_funct  in  6  D-stage funct field.
- i_FlushE  in  1  load a bubble into the E register at the next edge.
- o_RegWriteD, o_MemtoRegD, o_MemWriteD, o_ALUSrcD, o_RegDstD, o_BranchD, o_JumpD  out  1  D-stage decoded controls (combinational).
- o_ALUControlD  out  ALU_CTRL_W  D-stage ALU code.
- o_IllegalD  out  1  unsupported op/funct in D.
- o_RegWriteE, o_MemtoRegE, o_MemWriteE, o_ALUSrcE, o_RegDstE, o_MulStartE  out  1  E-stage registered controls.
- o_ALUControlE  out  ALU_CTRL_W  E-stage ALU code.
- o_RegWriteM, o_MemtoRegM, o_MemWriteM  out  1  M-stage controls.
- o_RegWriteW, o_MemtoRegW  out  1  W-stage controls.
- o_StallReq  out  1  stall request to hazard unit (multiply busy).
- o_MulDone  out  1  multiply result valid, one-cycle pulse.

## Operation
- Decode (ALU codes: add 010, sub 110, and 000, or 001, slt 111):
  - Op 000000, funct add/sub/and/or/slt (100000/100010/100100/100101/101010): RegWrite=1, RegDst=1, ALU per funct.
  - Op 000000, funct 011000 (MULT), ENABLE_MULDIV=1: all D controls 0, and a multiply start bit is carried into E.
  - lw 100011: RegWrite, ALUSrc, MemtoReg = 1; add.
  - sw 101011: MemWrite, ALUSrc = 1; add.
  - beq 000100: Branch=1; sub.
  - addi 001000: RegWrite, ALUSrc = 1; add.
  - j 000010: Jump=1.
  - Anything else: all controls 0, o_IllegalD=1.
- Branch and Jump resolve in D and are not pipelined.
- E register loads the D bundle each edge, except it loads all-zero when i_FlushE=1 or the FSM is BUSY. M and W registers always advance: E→M, M→W.
- Multiply FSM, states IDLE and BUSY, with a down-counter of width clog2(MULDIV_LAT):
  - IDLE→BUSY when a MULT is in D and i_FlushE=0. At that edge o_MulStartE becomes 1 and the counter loads MULDIV_LAT-2.
  - BUSY: o_StallReq=1 and the D decode is ignored for FSM purposes. The counter decrements each edge. o_MulDone=1 while the counter is 0. BUSY→IDLE on the edge where the counter is 0.
  - i_FlushE has no effect on the FSM while BUSY.

## Timing
- D outputs are combinational, zero latency. E/M/W outputs trail by 1/2/3 edges.
- Reset (i_RST=0, asynchronous): all E/M/W outputs 0, FSM IDLE, counter 0, o_StallReq=0, o_MulDone=0.
- Reset asserted mid-BUSY aborts the multiply. No o_MulDone is produced.
- BUSY lasts exactly MULDIV_LAT-1 cycles.
- o_StallReq and o_MulDone are Moore outputs (from state and counter only).
- With MULDIV_LAT=2: one BUSY cycle, in which o_StallReq=1 and o_MulDone=1 simultaneously.
- A back-to-back MULT held in D during BUSY starts on the first IDLE cycle, provided the hazard unit has released D.

## Test plan
- Reset: hold i_RST=0 with lw in D → all E/M/W outputs 0. Release → lw controls (RegWrite=1, MemtoReg=1, ALUSrc=1, ALU=010) appear at E after 1 edge, M after 2, W after 3.
- R-type decode sweep: op 0 with each of the five functs → o_ALUControlD = 010/110/000/001/111, RegDst=1. Then funct 000001 → o_IllegalD=1 and all controls 0.
- Flush: sw in D with i_FlushE=1 → o_MemWriteE=0 next cycle, and no MemWriteM the cycle after.
- MULT, MULDIV_LAT=4:
  - Edge 1: o_MulStartE=1.
  - Cycles 1–3: o_StallReq=1, E holds a bubble from cycle 2.
  - Cycle 3: o_MulDone=1.
  - Cycle 4: IDLE, stall released.
- MULT with i_FlushE=1 in IDLE → no BUSY entry, o_StallReq stays 0. With ENABLE_MULDIV=0 → o_IllegalD=1.
- Reset pulse in the second BUSY cycle → immediate IDLE, o_StallReq=0, o_MulDone never pulses.
